if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; feeds the decode stage.
//  Owns the PC, fetches instructions over a req/ack instruction-memory port, and
//  absorbs a stall arriving mid-fetch in a one-entry skid buffer.
//  Redirects on taken branch from downstream. Presents registered inst/pc4/debug tags.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous, active-low reset (0 = reset)
//  stall          in   1   hazard hold: outputs must not change while 1
//  br_taken       in   1   redirect/flush request, 1-cycle pulse
//  br_target      in   32  redirect PC, valid when br_taken=1
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (= pc)
//  imem_ack       in   1   transfer completes on cycle with imem_req & imem_ack
//  imem_rdata     in   32  instruction, valid on ack cycle
//  if_inst        out  32  fetched instruction (32'h0 = bubble/NOP)
//  if_pc4         out  32  address of if_inst + 4
//  if_valid       out  1   if_inst is a real instruction
//  IF_ins_type    out  4   debug class of if_inst
//  IF_ins_number  out  4   debug fetch sequence number
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, state=FETCH, skid empty, imem_req=0,
//   if_inst=0, if_pc4=0, if_valid=0, IF_ins_type=0, IF_ins_number=0.
//  Handshake: once imem_req=1, req and imem_addr stay stable until ack; ack may
//   arrive in the same cycle as req (zero-wait) or any later cycle.
//  States: FETCH (req=1 addr=pc), HOLD (req=0, skid full), DROP (req=1 old addr,
//   result discarded).
//  FETCH, priority br_taken > ack > stall:
//   br_taken: pc<=br_target; if_valid<=0, if_inst<=0, type<=0; ack same
//    cycle -> stay FETCH; no ack -> DROP (keep old addr until ack).
//   ack, stall=0: if_inst<=rdata, if_pc4<=pc+4, if_valid<=1, number<=number+1,
//    type<=class(rdata); pc<=pc+4.
//   ack, stall=1: skid<=rdata with pc+4; pc<=pc+4; outputs held; -> HOLD.
//   no ack, stall=0: bubble (if_valid<=0, if_inst<=0, type<=0, number held).
//   no ack, stall=1: outputs held.
//  HOLD: br_taken -> skid discarded, pc<=br_target, bubble, -> FETCH.
//   stall=0 -> skid loaded to outputs (valid=1, number+1), -> FETCH. else hold.
//  DROP: on ack discard rdata -> FETCH with redirected pc; no ack -> stay.
//   Bubble on outputs unless stall=1; a further br_taken overwrites pc.
//  Latency: 1 cycle from ack to if_inst when not stalled; sustained 1 inst/cycle
//   with zero-wait memory.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); number wraps 15->0.
//  class(opcode[31:26]): 000000->1, 100011->2, 101011->3, 00010x->4,
//   001xxx->5, 00001x->6, others->0.
//  Reset mid-fetch: outstanding request abandoned; ack during reset ignored.
// TESTING
//  Reset, zero-wait imem returning 32'h8C01_0004 at 0 -> cycle after ack:
//   if_inst=8C010004, if_pc4=4, valid=1, type=2, number=1; next addr=4.
//  Stall=1 asserted the cycle of ack for 0x00221820 at pc 8 -> outputs hold prior
//   inst; after stall drops, if_inst=00221820, if_pc4=C, req returns with addr=C.
//  ack delayed 3 cycles -> 3 bubbles (valid=0, inst=0), addr held stable throughout.
//  br_taken target 0x40 while req outstanding (no ack) -> DROP; old ack discarded;
//   next req addr=0x40; no instruction from old addr reaches if_inst.
//  RESET_PC=32'hFFFF_FFFC -> first if_pc4=0, second fetch addr=0; 17 fetches ->
//   number wraps to 1.
//  rst pulled low while in HOLD -> all outputs 0 immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch port, parks a
// fetch that completes under stall in a one-entry skid, and discards the
// in-flight fetch when a branch redirects while a request is outstanding.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, nxt_state;
  logic        started;          // keeps req low for the first cycle out of reset
  logic [31:0] pc, nxt_pc;
  logic [31:0] drop_addr, nxt_drop_addr;
  logic [31:0] skid_inst, nxt_skid_inst;
  logic [31:0] skid_pc4, nxt_skid_pc4;
  logic [31:0] nxt_inst, nxt_pc4_out;
  logic        nxt_valid;
  logic [3:0]  nxt_type, nxt_num;
  logic        xfer;
  logic [31:0] pc_plus4;

  // Debug class from the opcode field
  function automatic logic [3:0] ins_class(input logic [31:0] ins);
    casez (ins[31:26])
      6'b000000: ins_class = 4'd1;
      6'b100011: ins_class = 4'd2;
      6'b101011: ins_class = 4'd3;
      6'b00010?: ins_class = 4'd4;
      6'b001???: ins_class = 4'd5;
      6'b00001?: ins_class = 4'd6;
      default:   ins_class = 4'd0;
    endcase
  endfunction

  assign imem_req  = started && (state != HOLD);
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign xfer      = imem_req && imem_ack;
  assign pc_plus4  = pc + 32'd4;

  // Next-state and datapath updates; everything holds unless changed below
  always_comb begin
    nxt_state     = state;
    nxt_pc        = pc;
    nxt_drop_addr = drop_addr;
    nxt_skid_inst = skid_inst;
    nxt_skid_pc4  = skid_pc4;
    nxt_inst      = if_inst;
    nxt_pc4_out   = if_pc4;
    nxt_valid     = if_valid;
    nxt_type      = IF_ins_type;
    nxt_num       = IF_ins_number;
    unique case (state)
      FETCH: begin
        if (br_taken) begin
          nxt_pc    = br_target;
          nxt_valid = 1'b0;
          nxt_inst  = 32'h0;
          nxt_type  = 4'd0;
          // an unanswered request must run to its ack at the old address
          if (imem_req && !imem_ack) begin
            nxt_state     = DROP;
            nxt_drop_addr = pc;
          end
        end else if (xfer) begin
          nxt_pc = pc_plus4;
          if (!stall) begin
            nxt_inst    = imem_rdata;
            nxt_pc4_out = pc_plus4;
            nxt_valid   = 1'b1;
            nxt_type    = ins_class(imem_rdata);
            nxt_num     = IF_ins_number + 4'd1;
          end else begin
            nxt_skid_inst = imem_rdata;
            nxt_skid_pc4  = pc_plus4;
            nxt_state     = HOLD;
          end
        end else if (!stall) begin
          nxt_valid = 1'b0;
          nxt_inst  = 32'h0;
          nxt_type  = 4'd0;
        end
      end
      HOLD: begin
        if (br_taken) begin
          nxt_pc    = br_target;
          nxt_valid = 1'b0;
          nxt_inst  = 32'h0;
          nxt_type  = 4'd0;
          nxt_state = FETCH;
        end else if (!stall) begin
          nxt_inst    = skid_inst;
          nxt_pc4_out = skid_pc4;
          nxt_valid   = 1'b1;
          nxt_type    = ins_class(skid_inst);
          nxt_num     = IF_ins_number + 4'd1;
          nxt_state   = FETCH;
        end
      end
      DROP: begin
        if (br_taken) nxt_pc = br_target;
        if (imem_ack) nxt_state = FETCH;
        if (!stall || br_taken) begin
          nxt_valid = 1'b0;
          nxt_inst  = 32'h0;
          nxt_type  = 4'd0;
        end
      end
      default: nxt_state = FETCH;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH;
      started       <= 1'b0;
      pc            <= RESET_PC;
      drop_addr     <= 32'h0;
      skid_inst     <= 32'h0;
      skid_pc4      <= 32'h0;
      if_inst       <= 32'h0;
      if_pc4        <= 32'h0;
      if_valid      <= 1'b0;
      IF_ins_type   <= 4'd0;
      IF_ins_number <= 4'd0;
    end else begin
      state         <= nxt_state;
      started       <= 1'b1;
      pc            <= nxt_pc;
      drop_addr     <= nxt_drop_addr;
      skid_inst     <= nxt_skid_inst;
      skid_pc4      <= nxt_skid_pc4;
      if_inst       <= nxt_inst;
      if_pc4        <= nxt_pc4_out;
      if_valid      <= nxt_valid;
      IF_ins_type   <= nxt_type;
      IF_ins_number <= nxt_num;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios; delivered instructions are
// checked against a queue of hand-computed expectations by a monitor.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [3:0]  typ;
    logic [3:0]  num;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, imem_ack;
  logic [31:0] br_target, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_inst, if_pc4;
  logic [3:0]  IF_ins_type, IF_ins_number;

  logic        req2, valid2;
  logic [31:0] addr2, inst2, pc42;
  logic [3:0]  type2, num2;

  int   vectors = 0;
  int   miscompares = 0;
  bit   dut2_done = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
    .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number));

  // Wrap-around instance: zero-wait memory, never stalled or redirected
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .br_taken(1'b0), .br_target(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_rdata(32'h0000_0000),
    .if_inst(inst2), .if_pc4(pc42), .if_valid(valid2),
    .IF_ins_type(type2), .IF_ins_number(num2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [3:0] t,
                      input logic [3:0] n);
    exp_t e;
    e.inst = i; e.pc4 = p; e.typ = t; e.num = n;
    sb.push_back(e);
  endtask

  // Monitor: each newly presented instruction (sequence number moved while valid)
  // must match the oldest expectation
  logic [3:0] last_num = 4'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && if_valid && IF_ins_number != last_num) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_inst: got %h expected none", if_inst);
      end else begin
        e = sb.pop_front();
        chk("sb_inst", if_inst, e.inst);
        chk("sb_pc4", if_pc4, e.pc4);
        chk("sb_type", {28'h0, IF_ins_type}, {28'h0, e.typ});
        chk("sb_number", {28'h0, IF_ins_number}, {28'h0, e.num});
      end
    end
    last_num = IF_ins_number;
  end

  // Wrap-around checks on the second instance after the first reset release
  initial begin
    @(posedge rst);
    cyc();
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_first_req", {31'h0, req2}, 32'h1);
    cyc();
    chk("wrap_pc4", pc42, 32'h0);
    chk("wrap_valid", {31'h0, valid2}, 32'h1);
    chk("wrap_second_addr", addr2, 32'h0);
    repeat (16) cyc();
    chk("wrap_number", {28'h0, num2}, 32'h1);
    dut2_done = 1'b1;
  end

  initial begin
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #2;
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_type", {28'h0, IF_ins_type}, 32'h0);
    chk("rst_number", {28'h0, IF_ins_number}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // zero-wait back-to-back fetches
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; push(32'h8C01_0004, 32'h4, 4'd2, 4'd1);
    cyc();
    chk("addr_after_1", imem_addr, 32'h4);
    imem_rdata = 32'h2001_0005; push(32'h2001_0005, 32'h8, 4'd5, 4'd2);
    cyc();
    chk("addr_after_2", imem_addr, 32'h8);

    // stall on the ack cycle: instruction parks in the skid
    imem_rdata = 32'h0022_1820; stall = 1'b1;
    cyc();
    imem_ack = 1'b0;
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_inst", if_inst, 32'h2001_0005);
    cyc();
    chk("hold_inst2", if_inst, 32'h2001_0005);
    chk("hold_number", {28'h0, IF_ins_number}, 32'h2);
    stall = 1'b0; push(32'h0022_1820, 32'hC, 4'd1, 4'd3);
    cyc();
    chk("skid_req", {31'h0, imem_req}, 32'h1);
    chk("skid_addr", imem_addr, 32'hC);

    // slow memory: three bubbles with a stable address
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_valid", {31'h0, if_valid}, 32'h0);
      chk("wait_inst", if_inst, 32'h0);
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_req", {31'h0, imem_req}, 32'h1);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1022_0003; push(32'h1022_0003, 32'h10, 4'd4, 4'd4);
    cyc();
    imem_ack = 1'b0;
    chk("addr_after_beq", imem_addr, 32'h10);

    // redirect while the fetch at 0x10 is unanswered
    cyc();
    br_taken = 1'b1; br_target = 32'h40;
    cyc();
    br_taken = 1'b0;
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_valid", {31'h0, if_valid}, 32'h0);
    cyc();
    chk("drop_addr2", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_inst", if_inst, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010; push(32'h0800_0010, 32'h44, 4'd6, 4'd5);
    cyc();
    chk("addr_after_j", imem_addr, 32'h44);

    // redirect on the same cycle as a zero-wait ack: result discarded, no DROP
    br_taken = 1'b1; br_target = 32'h80; imem_rdata = 32'hAC22_0000;
    cyc();
    br_taken = 1'b0;
    chk("br_ack_addr", imem_addr, 32'h80);
    chk("br_ack_valid", {31'h0, if_valid}, 32'h0);
    push(32'hAC22_0000, 32'h84, 4'd3, 4'd6);
    cyc();
    imem_ack = 1'b0;
    chk("addr_after_sw", imem_addr, 32'h84);

    for (int i = 0; i < 100 && !dut2_done; i++) cyc();
    chk("wrap_finished", {31'h0, dut2_done}, 32'h1);

    // reset while parked in HOLD
    imem_ack = 1'b1; stall = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_ack = 1'b0;
    chk("hold2_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("arst_inst", if_inst, 32'h0);
    chk("arst_pc4", if_pc4, 32'h0);
    chk("arst_valid", {31'h0, if_valid}, 32'h0);
    chk("arst_number", {28'h0, IF_ins_number}, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    #1;
    rst = 1'b1;
    cyc();
    chk("refetch_addr", imem_addr, 32'h0);
    chk("refetch_req", {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h3C01_0001; push(32'h3C01_0001, 32'h4, 4'd5, 4'd1);
    cyc();
    imem_ack = 1'b0;
    cyc(); cyc();
    chk("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
